// File: rtl/keypad_entry.sv
// Calculator key-entry front end: builds a signed operand from digit/sign/edit keys
// and hands it to the ALU over a valid/ready handshake.
module keypad_entry #(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned MAX_DIGITS = 3,
  parameter int unsigned MAX_MAG    = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             key_valid,
  input  logic [3:0]       key_code,
  output logic             key_ready,
  output logic             key_err,
  output logic [WIDTH-1:0] entry_value,
  output logic [1:0]       digit_count,
  output logic [WIDTH-1:0] operand,
  output logic             operand_valid,
  input  logic             operand_ready
);

  localparam int unsigned EW = WIDTH + 4;

  typedef enum logic [1:0] {S_IDLE, S_ENTRY, S_HOLD} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] mag_q, mag_d;
  logic [WIDTH-1:0] operand_q, operand_d;
  logic             neg_q, neg_d;
  logic             opv_q, opv_d;
  logic             err_q, err_d;
  logic [1:0]       cnt_q, cnt_d;
  logic [EW-1:0]    next_mag;
  logic [WIDTH-1:0] signed_val;

  // Widened so an over-range candidate is seen as such rather than wrapping.
  assign next_mag   = EW'(mag_q) * EW'(10) + EW'(key_code);
  assign signed_val = neg_q ? (~mag_q + WIDTH'(1)) : mag_q;

  always_comb begin
    state_d   = state_q;
    mag_d     = mag_q;
    neg_d     = neg_q;
    cnt_d     = cnt_q;
    operand_d = operand_q;
    opv_d     = opv_q;
    err_d     = 1'b0;
    if (state_q == S_HOLD) begin
      if (operand_ready) begin
        opv_d   = 1'b0;
        mag_d   = '0;
        neg_d   = 1'b0;
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    end else if (key_valid) begin
      case (key_code)
        4'hA: neg_d = ~neg_q;
        4'hB: begin
          if (cnt_q == 2'd0) begin
            err_d = 1'b1;
          end else begin
            mag_d = mag_q / WIDTH'(10);
            cnt_d = cnt_q - 2'd1;
          end
        end
        4'hC: begin
          mag_d = '0;
          neg_d = 1'b0;
          cnt_d = '0;
        end
        4'hE: begin
          operand_d = signed_val;
          opv_d     = 1'b1;
        end
        4'hD, 4'hF: err_d = 1'b1;
        default: begin
          if ((mag_q == '0) && (key_code == 4'd0)) begin
            err_d = 1'b0;
          end else if ((cnt_q == 2'(MAX_DIGITS)) || (next_mag > EW'(MAX_MAG))) begin
            err_d = 1'b1;
          end else begin
            mag_d = next_mag[WIDTH-1:0];
            cnt_d = cnt_q + 2'd1;
          end
        end
      endcase
      if (opv_d)
        state_d = S_HOLD;
      else if ((cnt_d != 2'd0) || neg_d)
        state_d = S_ENTRY;
      else
        state_d = S_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      mag_q     <= '0;
      neg_q     <= 1'b0;
      cnt_q     <= '0;
      operand_q <= '0;
      opv_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      mag_q     <= mag_d;
      neg_q     <= neg_d;
      cnt_q     <= cnt_d;
      operand_q <= operand_d;
      opv_q     <= opv_d;
      err_q     <= err_d;
    end
  end

  assign key_ready     = (state_q != S_HOLD);
  assign key_err       = err_q;
  assign entry_value   = signed_val;
  assign digit_count   = cnt_q;
  assign operand       = operand_q;
  assign operand_valid = opv_q;

endmodule

// File: tb/tb_keypad_entry.sv
// Scoreboard bench for keypad_entry: a digit-list reference model predicts every
// cycle's outputs; a monitor pops and compares after each clock edge.
module tb_keypad_entry;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        key_valid = 1'b0;
  logic [3:0]  key_code = '0;
  logic        key_ready;
  logic        key_err;
  logic [15:0] entry_value;
  logic [1:0]  digit_count;
  logic [15:0] operand;
  logic        operand_valid;
  logic        operand_ready = 1'b0;

  int checks = 0;
  int errors = 0;

  keypad_entry #(.WIDTH(16), .MAX_DIGITS(3), .MAX_MAG(255)) dut (
    .clk(clk), .rst_n(rst_n), .key_valid(key_valid), .key_code(key_code),
    .key_ready(key_ready), .key_err(key_err), .entry_value(entry_value),
    .digit_count(digit_count), .operand(operand), .operand_valid(operand_valid),
    .operand_ready(operand_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] entry;
    int          count;
    logic        err;
    logic        ready;
    logic        valid;
    logic [15:0] op;
    logic        chk_op;
  } exp_t;

  exp_t exp_q[$];

  // Reference model: the number is the list of typed digits plus a sign flag.
  int digits[$];
  bit m_neg  = 0;
  bit m_hold = 0;
  int m_op   = 0;

  function automatic int mag_of();
    int m = 0;
    foreach (digits[i]) m = m * 10 + digits[i];
    return m;
  endfunction

  function automatic exp_t model_step(bit rst, bit kv, int kc, bit rdy);
    exp_t e;
    int   m;
    e.err = 0;
    e.chk_op = 0;
    if (!rst) begin
      digits.delete();
      m_neg = 0; m_hold = 0; m_op = 0;
      e.chk_op = 1;
    end else if (m_hold) begin
      if (rdy) begin
        m_hold = 0; m_neg = 0; digits.delete();
      end
    end else if (kv) begin
      m = mag_of();
      if (kc <= 9) begin
        if (!(m == 0 && kc == 0)) begin
          if (digits.size() == 3 || m * 10 + kc > 255) e.err = 1;
          else digits.push_back(kc);
        end
      end else if (kc == 10) m_neg = !m_neg;
      else if (kc == 11) begin
        if (digits.size() == 0) e.err = 1;
        else void'(digits.pop_back());
      end else if (kc == 12) begin
        digits.delete(); m_neg = 0;
      end else if (kc == 14) begin
        m_op = m_neg ? -m : m;
        m_hold = 1;
      end else e.err = 1;
    end
    m = mag_of();
    e.entry = 16'(m_neg ? -m : m);
    e.count = digits.size();
    e.ready = !m_hold;
    e.valid = m_hold;
    e.op    = 16'(m_op);
    if (m_hold) e.chk_op = 1;
    return e;
  endfunction

  task automatic chk(string name, int act, int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s at %0t: got %0d (0x%0h) expected %0d (0x%0h)", name, $time, act, act, req, req);
    end
  endtask

  // Inputs change on the falling edge; the prediction covers the next rising edge.
  task automatic drive(bit rst, bit kv, int kc, bit rdy);
    @(negedge clk);
    rst_n = rst;
    key_valid = kv;
    key_code = 4'(kc);
    operand_ready = rdy;
    exp_q.push_back(model_step(rst, kv && !m_hold, kc, rdy));
  endtask

  task automatic key(int kc, bit rdy = 1);
    drive(1, 1, kc, rdy);
  endtask

  task automatic idle(int n, bit rdy = 1);
    for (int i = 0; i < n; i++) drive(1, 0, 0, rdy);
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("entry_value", int'(entry_value), int'(e.entry));
      chk("digit_count", int'(digit_count), e.count);
      chk("key_err", int'(key_err), int'(e.err));
      chk("key_ready", int'(key_ready), int'(e.ready));
      chk("operand_valid", int'(operand_valid), int'(e.valid));
      if (e.chk_op) chk("operand", int'(operand), int'(e.op));
    end
  end

  initial begin
    drive(0, 0, 0, 0);
    drive(0, 0, 0, 0);
    // basic entry and handoff
    key(1); key(2); key(3); key(14); idle(2);
    // over-range digit rejected
    key(2); key(5); key(6); key(12);
    // negative entry
    key(10); key(4); key(2); key(14); idle(2);
    // leading zeros, backspace to empty, backspace error
    key(0); key(0); key(7); key(11); key(11); key(14); idle(2);
    // digit-count limit and D/F
    key(1); key(2); key(3); key(4); key(13); key(15); key(10); key(10); key(12);
    // held operand with keys pulsed
    key(5); key(14, 0);
    for (int i = 0; i < 5; i++) key(9, 0);
    idle(1, 1); idle(1, 1);
    // negate alone, enter emits zero
    key(10); key(14); idle(2);
    // reset mid-entry
    key(8); key(10); drive(0, 1, 3, 0); key(3); key(12);
    // reset mid-hold
    key(6); key(14, 0); idle(2, 0); drive(0, 0, 0, 0); idle(1);
    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      int r = $urandom_range(0, 99);
      int kc = ($urandom_range(0, 3) == 0) ? $urandom_range(10, 15) : $urandom_range(0, 9);
      drive(r != 0, $urandom_range(0, 9) < 7, kc, $urandom_range(0, 1) == 1);
    end
    idle(1);
    @(posedge clk);
    #3;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
